// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: feeds padded 512-bit blocks to an iterative sha256
// compression core one at a time and chains each block's digest into the next
// block. When the last block finishes, the final digest is held until the
// consumer takes it. A watchdog aborts the message if the core stalls.
module sha256_block_sequencer #(
    parameter logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
    parameter int           CNT_W   = 16,
    parameter int           TIMEOUT = 80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_last,
    output logic [255:0]     core_h,
    output logic [511:0]     core_m,
    output logic             core_start,
    input  logic             core_done,
    input  logic [255:0]     core_digest,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic [255:0]     digest,
    output logic [CNT_W-1:0] blk_count,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            accept, done_hit, wd_expired, dig_take;
    logic [WD_W-1:0] wdog;
    logic [255:0]    chain;
    logic            first;
    logic            last_q;

    // Ready only while idle and out of reset, so nothing is accepted during reset.
    assign blk_ready = rst_n && (state == IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and event decode. A core_done coinciding with the launch
    // pulse is stale (left over from an aborted block) and is ignored; a
    // genuine completion in the watchdog's final cycle wins over the abort.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        done_hit   = 1'b0;
        wd_expired = 1'b0;
        dig_take   = 1'b0;
        case (state)
            IDLE: begin
                if (blk_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (core_done && !core_start) begin
                    done_hit  = 1'b1;
                    state_nxt = last_q ? DONE : IDLE;
                end else if (wdog == WD_W'(TIMEOUT)) begin
                    wd_expired = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            DONE: begin
                if (digest_ready) begin
                    dig_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: launch registers, chaining value, watchdog, counters, digest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_h       <= IV;
            core_m       <= '0;
            core_start   <= 1'b0;
            chain        <= IV;
            first        <= 1'b1;
            last_q       <= 1'b0;
            wdog         <= '0;
            blk_count    <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            core_start  <= accept;
            timeout_err <= wd_expired;

            if (accept) begin
                core_m <= blk_data;
                core_h <= first ? IV : chain;
                last_q <= blk_last;
                wdog   <= '0;
            end else if (state == RUN) begin
                if (done_hit || wd_expired) wdog <= '0;
                else                        wdog <= wdog + WD_W'(1);
            end

            if (done_hit) begin
                chain <= core_digest;
                if (blk_count != '1) blk_count <= blk_count + CNT_W'(1);
                if (last_q) begin
                    digest       <= core_digest;
                    digest_valid <= 1'b1;
                end else begin
                    first <= 1'b0;
                end
            end

            if (wd_expired) begin
                first     <= 1'b1;
                blk_count <= '0;
            end

            if (dig_take) begin
                digest_valid <= 1'b0;
                first        <= 1'b1;
                blk_count    <= '0;
            end
        end
    end

endmodule
